// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmitter.
//   spi_tx_state_e : transmitter FSM states
//   SPI_WORD_W     : default word width
//   frame_cycles() : clk cycles SS stays low for one frame of a given width and divider
package spi_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_tx_state_e;

  function automatic int frame_cycles(int width, int div);
    return (2 * width + 1) * div;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   load  : reload the counter with CLK_DIV-1 (asserted on every FSM state entry)
//   en    : allow the counter to count down
//   tick  : counter has reached zero; the current half-period ends at the next edge
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CntW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= Reload;
    end else if (load) begin
      cnt_q <= Reload;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmitter, mode 0, MSB first. Accepts one word per valid/ready handshake and
// sends it as one SS-low frame, followed by at least GAP_CYCLES clk cycles with SS high.
//   clk      : system clock
//   reset    : asynchronous active-low reset (aborts any frame in flight)
//   in_valid : in_data is valid
//   in_ready : block can accept a word (registered, high only in IDLE)
//   in_data  : word to transmit
//   busy     : frame or inter-frame gap in progress
//   SS       : slave select, active low
//   SCLK     : serial clock, idles low
//   MOSI     : serial data, changes on SCLK falling edge
//   tx_count : completed frames, wraps (only with SPI_MASTER_TX_WORD_CNT_EN defined)
// Optional feature macro: SPI_MASTER_TX_WORD_CNT_EN.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_WORD_W,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  SS,
  output logic                  SCLK,
  output logic                  MOSI
`ifdef SPI_MASTER_TX_WORD_CNT_EN
  ,
  output logic [31:0]           tx_count
`endif
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_tx: CLK_DIV must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
    $error("spi_master_tx: GAP_CYCLES must be >= 1");
  end

  localparam int BitW = $clog2(DATA_WIDTH + 1);
  localparam int GapW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  spi_tx_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_next;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                  ss_q, ss_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  tick;

  // Every state change restarts the half-period count.
  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .load (state_d != state_q),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  assign shift_next = shift_q << 1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          shift_d   = in_data;
          bit_cnt_d = BitW'(DATA_WIDTH);
          ss_d      = 1'b0;
          mosi_d    = in_data[DATA_WIDTH-1];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - BitW'(1);
          if (bit_cnt_q != BitW'(1)) begin
            shift_d = shift_next;
            mosi_d  = shift_next[DATA_WIDTH-1];
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end
        end
      end
      LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HOLD: begin
        if (tick) begin
          ss_d      = 1'b1;
          gap_cnt_d = GapW'(GAP_CYCLES - 1);
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they stay glitch-free registers.
  assign in_ready_d = (state_d == IDLE);
  assign busy_d     = (state_d != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign SS       = ss_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;

`ifdef SPI_MASTER_TX_WORD_CNT_EN
  logic        frame_done;
  logic [31:0] tx_count_q;

  // Counted only on the orderly SS rise; a reset abort never reaches this point.
  assign frame_done = (state_q == HOLD) && tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_count_q <= '0;
    end else if (frame_done) begin
      tx_count_q <= tx_count_q + 32'd1;
    end
  end

  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx. Two instances: defaults (CLK_DIV=2, GAP_CYCLES=2) and
// the minimum corner (CLK_DIV=1, GAP_CYCLES=1). A cycle-level model derives every output from
// the accept time and word; a receiver rebuilds each frame from SCLK rises.
module tb_spi_master_tx;

  localparam int W    = 32;
  localparam int DIV0 = 2;
  localparam int GAP0 = 2;
  localparam int DIV1 = 1;
  localparam int GAP1 = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   in_valid;
  logic [W-1:0] in_data [2];
  logic [1:0]   in_ready, busy, ss, sclk, mosi;
`ifdef SPI_MASTER_TX_WORD_CNT_EN
  logic [31:0]  txc [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_WIDTH(W), .CLK_DIV(DIV0), .GAP_CYCLES(GAP0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .busy(busy[0]), .SS(ss[0]), .SCLK(sclk[0]), .MOSI(mosi[0])
`ifdef SPI_MASTER_TX_WORD_CNT_EN
    , .tx_count(txc[0])
`endif
  );

  spi_master_tx #(.DATA_WIDTH(W), .CLK_DIV(DIV1), .GAP_CYCLES(GAP1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .busy(busy[1]), .SS(ss[1]), .SCLK(sclk[1]), .MOSI(mosi[1])
`ifdef SPI_MASTER_TX_WORD_CNT_EN
    , .tx_count(txc[1])
`endif
  );

  function automatic int div_of(int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int gap_of(int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  function automatic int frame_len(int i);
    return (2 * W + 1) * div_of(i);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int           cyc = 0;
  bit           m_started [2];
  bit           m_ready [2];
  bit           m_active [2];
  int           m_acc [2];
  int           m_ready_at [2];
  logic [W-1:0] m_word [2];
  logic [W-1:0] exp_words [2][64];
  int           n_exp [2];
  int           n_acc [2];
  int           acc_cyc [2][16];

  // Receiver state
  bit           r_in [2];
  logic         r_prev_ss [2];
  logic         r_prev_sclk [2];
  logic [W-1:0] r_word [2];
  int           r_len [2];
  int           r_rises [2];
  int           r_high [2];
  int           r_last_high [2];
  int           n_rx [2];
  logic [W-1:0] rx_hist [2][64];
  int           rx_len_hist [2][64];

  // Model: in_ready is high from the first edge after reset, drops on accept and returns
  // frame_len + GAP cycles after the accept edge.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_started[i] = 1'b0;
        m_ready[i]   = 1'b0;
        m_active[i]  = 1'b0;
        n_exp[i]     = n_rx[i];
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          acc_cyc[i][n_acc[i] % 16] = cyc;
          n_acc[i]++;
        end
        if (!m_started[i]) begin
          m_started[i] = 1'b1;
          m_ready[i]   = 1'b1;
        end else if (m_ready[i] && in_valid[i]) begin
          m_ready[i]    = 1'b0;
          m_active[i]   = 1'b1;
          m_acc[i]      = cyc;
          m_word[i]     = in_data[i];
          m_ready_at[i] = cyc + frame_len(i) + gap_of(i);
          exp_words[i][n_exp[i] % 64] = in_data[i];
          n_exp[i]++;
        end else if (!m_ready[i] && cyc >= m_ready_at[i]) begin
          m_ready[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare plus frame receiver, sampled on the falling clk edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic         e_ss, e_sclk, e_mosi;
      logic [W-1:0] e_word;
      int           t, j;
      e_ss = 1'b1;
      e_sclk = 1'b0;
      e_mosi = 1'b0;
      if (m_active[i]) begin
        t = cyc - m_acc[i];
        if (t < frame_len(i)) begin
          e_ss = 1'b0;
          j = t / (2 * div_of(i));
          if (j < W) begin
            e_mosi = m_word[i][W-1-j];
            e_sclk = (t % (2 * div_of(i))) >= div_of(i);
          end
        end
      end
      check($sformatf("outputs dut%0d cyc %0d (SS SCLK MOSI RDY BUSY)", i, cyc),
            {ss[i], sclk[i], mosi[i], in_ready[i], busy[i]},
            {e_ss, e_sclk, e_mosi, m_ready[i], m_started[i] && !m_ready[i]});

      if (!reset) begin
        r_in[i]        = 1'b0;
        r_prev_ss[i]   = 1'b1;
        r_prev_sclk[i] = 1'b0;
        r_high[i]      = 0;
      end else begin
        if (r_prev_ss[i] && !ss[i]) begin
          r_in[i]        = 1'b1;
          r_len[i]       = 0;
          r_rises[i]     = 0;
          r_word[i]      = '0;
          r_last_high[i] = r_high[i];
          r_high[i]      = 0;
        end
        if (!ss[i]) begin
          r_len[i]++;
          if (sclk[i] && !r_prev_sclk[i]) begin
            r_word[i] = {r_word[i][W-2:0], mosi[i]};
            r_rises[i]++;
          end
        end else begin
          r_high[i]++;
        end
        if (!r_prev_ss[i] && ss[i] && r_in[i]) begin
          r_in[i] = 1'b0;
          e_word = (n_rx[i] < n_exp[i]) ? exp_words[i][n_rx[i] % 64] : 'x;
          check($sformatf("rx word dut%0d frame %0d", i, n_rx[i]), r_word[i], e_word);
          rx_hist[i][n_rx[i] % 64]     = r_word[i];
          rx_len_hist[i][n_rx[i] % 64] = r_len[i];
          n_rx[i]++;
        end
        r_prev_ss[i]   = ss[i];
        r_prev_sclk[i] = sclk[i];
      end
    end
  end

  task automatic send(int i, logic [W-1:0] w, bit hold);
    int base;
    int k;
    @(negedge clk);
    base = n_acc[i];
    k = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = w;
    while (n_acc[i] == base && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("accept dut%0d word %0h", i, w), n_acc[i] - base, 1);
    if (!hold) in_valid[i] = 1'b0;
  endtask

  task automatic wait_rx(int i, int target);
    int k;
    k = 0;
    while (n_rx[i] < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("frame count dut%0d", i), n_rx[i], target);
  endtask

  initial begin
    int base;
    int a0;
    in_valid   = 2'b00;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(negedge clk);
    check("reset SS", ss, 2'b11);
    check("reset SCLK", sclk, 2'b00);
    check("reset MOSI", mosi, 2'b00);
    check("reset in_ready", in_ready, 2'b00);
    check("reset busy", busy, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready after release", in_ready, 2'b11);

    // Single word
    base = n_rx[0];
    send(0, 32'hA5C30F81, 1'b0);
    wait_rx(0, base + 1);
    check("single word", rx_hist[0][base % 64], 32'hA5C30F81);
    check("single SS low cycles", rx_len_hist[0][base % 64], 130);
    check("single SCLK rises", r_rises[0], 32);

    // Back-to-back with in_valid held
    base = n_rx[0];
    a0   = n_acc[0];
    send(0, 32'h00000013, 1'b1);
    send(0, 32'hDEADBEEF, 1'b1);
    send(0, 32'h12345678, 1'b0);
    check("b2b period 1", acc_cyc[0][(a0 + 1) % 16] - acc_cyc[0][a0 % 16], 133);
    check("b2b period 2", acc_cyc[0][(a0 + 2) % 16] - acc_cyc[0][(a0 + 1) % 16], 133);
    wait_rx(0, base + 3);
    check("b2b word 0", rx_hist[0][base % 64], 32'h00000013);
    check("b2b word 1", rx_hist[0][(base + 1) % 64], 32'hDEADBEEF);
    check("b2b word 2", rx_hist[0][(base + 2) % 64], 32'h12345678);
    check("b2b SS high >= 2", r_last_high[0] >= 2, 1);

    // Busy ignore
    base = n_rx[0];
    a0   = n_acc[0];
    send(0, 32'h0F0F0F0F, 1'b0);
    repeat (20) @(negedge clk);
    check("busy in_ready", in_ready[0], 1'b0);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_rx(0, base + 1);
    check("busy accepts", n_acc[0] - a0, 1);
    check("busy word", rx_hist[0][base % 64], 32'h0F0F0F0F);

    // Reset abort after 10 SCLK rises, then recover
    base = n_rx[0];
    send(0, 32'hCAFEBABE, 1'b0);
    a0 = 0;
    while (r_rises[0] < 10 && a0 < 1000) begin
      @(negedge clk);
      a0++;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort SS", ss, 2'b11);
    check("abort SCLK", sclk, 2'b00);
    check("abort MOSI", mosi, 2'b00);
    check("abort busy", busy, 2'b00);
    check("abort in_ready", in_ready, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(0, 32'h80000001, 1'b0);
    wait_rx(0, base + 1);
    check("recover word", rx_hist[0][base % 64], 32'h80000001);
`ifdef SPI_MASTER_TX_WORD_CNT_EN
    check("tx_count dut0 after abort", txc[0], 32'd1);
    check("tx_count dut1 after abort", txc[1], 32'd0);
`endif

    // Corner: CLK_DIV=1, GAP_CYCLES=1
    base = n_rx[1];
    a0   = n_acc[1];
    send(1, 32'hFFFFFFFF, 1'b1);
    send(1, 32'h00000000, 1'b0);
    wait_rx(1, base + 2);
    check("corner period", acc_cyc[1][(a0 + 1) % 16] - acc_cyc[1][a0 % 16], 67);
    check("corner word 0", rx_hist[1][base % 64], 32'hFFFFFFFF);
    check("corner word 1", rx_hist[1][(base + 1) % 64], 32'h00000000);
    check("corner SS low 0", rx_len_hist[1][base % 64], 65);
    check("corner SS low 1", rx_len_hist[1][(base + 1) % 64], 65);
`ifdef SPI_MASTER_TX_WORD_CNT_EN
    check("tx_count dut1 corner", txc[1], 32'd2);
`endif

    // Random words, random spacing and stray in_valid pulses
    for (int n = 0; n < 8; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(i, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        in_valid[i] = 1'b1;
        in_data[i]  = $urandom;
        @(negedge clk);
        in_valid[i] = 1'b0;
      end
    end
    in_valid = 2'b00;
    repeat (400) @(negedge clk);
    check("all frames received dut0", n_rx[0], n_exp[0]);
    check("all frames received dut1", n_rx[1], n_exp[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
